soc_axi_lite_sys: RTL and testbench

- SoC top-level shell for the CPU performance/functional test platform.
- Hosts the configuration-register peripheral behind an AXI4-Lite slave port. The CPU core and interconnect sit outside this block and drive the `s_*` port.
- Drives board GPIO: LEDs, bicolour LEDs, 8-digit seven-segment display and keypad.
- Exposes bench-visible monitor signals: `num_data`, `num_monitor`, virtual UART and `open_trace`.

---
 rtl/soc_cfg_pkg.sv | 59 +++++
 rtl/soc_axi_lite_sys_confreg.sv | 242 ++++++++++++++++++++++++
 rtl/soc_axi_lite_sys.sv | 110 +++++++++++
 tb/tb_soc_axi_lite_sys.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/soc_cfg_pkg.sv
// Shared constants for the SoC confreg shell: register offsets, response code,
// AXI-Lite slave state types and small helpers (byte-lane merge, hex-to-segment).
package soc_cfg_pkg;

   localparam logic [1:0]  RESP_OKAY        = 2'b00;

   localparam logic [15:0] ADDR_CR0         = 16'h8000;
   localparam logic [15:0] ADDR_TIMER       = 16'hE000;
   localparam logic [15:0] ADDR_LED         = 16'hF000;
   localparam logic [15:0] ADDR_LED_RG0     = 16'hF004;
   localparam logic [15:0] ADDR_LED_RG1     = 16'hF008;
   localparam logic [15:0] ADDR_NUM         = 16'hF010;
   localparam logic [15:0] ADDR_SWITCH      = 16'hF020;
   localparam logic [15:0] ADDR_BTN_KEY     = 16'hF024;
   localparam logic [15:0] ADDR_BTN_STEP    = 16'hF028;
   localparam logic [15:0] ADDR_VUART       = 16'hFFF0;
   localparam logic [15:0] ADDR_SIMU_FLAG   = 16'hFFF4;
   localparam logic [15:0] ADDR_OPEN_TRACE  = 16'hFFF8;
   localparam logic [15:0] ADDR_NUM_MONITOR = 16'hFFFC;

   typedef enum logic {WR_IDLE, WR_RESP} wr_state_e;
   typedef enum logic {RD_IDLE, RD_DATA} rd_state_e;

   function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
      logic [31:0] res;
      res = old_val;
      for (int unsigned b = 0; b < 4; b++) begin
         if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
      end
      return res;
   endfunction

   // Segment order is {a,b,c,d,e,f,g}, a in bit 6, active-high
   function automatic logic [6:0] hex2seg(input logic [3:0] nib);
      logic [6:0] seg;
      case (nib)
         4'h0: seg = 7'b1111110;
         4'h1: seg = 7'b0110000;
         4'h2: seg = 7'b1101101;
         4'h3: seg = 7'b1111001;
         4'h4: seg = 7'b0110011;
         4'h5: seg = 7'b1011011;
         4'h6: seg = 7'b1011111;
         4'h7: seg = 7'b1110000;
         4'h8: seg = 7'b1111111;
         4'h9: seg = 7'b1111011;
         4'hA: seg = 7'b1110111;
         4'hB: seg = 7'b0011111;
         4'hC: seg = 7'b1001110;
         4'hD: seg = 7'b0111101;
         4'hE: seg = 7'b1001111;
         default: seg = 7'b1000111;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/soc_axi_lite_sys_confreg.sv
// Configuration register file behind an AXI4-Lite slave port; independent
// write (AW/W latched separately) and read state machines.
module confreg
   import soc_cfg_pkg::*;
#(
   parameter int unsigned SIMULATION = 0
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic [15:0] s_awaddr_i,
   input  logic        s_awvalid_i,
   output logic        s_awready_o,
   input  logic [31:0] s_wdata_i,
   input  logic [3:0]  s_wstrb_i,
   input  logic        s_wvalid_i,
   output logic        s_wready_o,
   output logic [1:0]  s_bresp_o,
   output logic        s_bvalid_o,
   input  logic        s_bready_i,
   input  logic [15:0] s_araddr_i,
   input  logic        s_arvalid_i,
   output logic        s_arready_o,
   output logic [31:0] s_rdata_o,
   output logic [1:0]  s_rresp_o,
   output logic        s_rvalid_o,
   input  logic        s_rready_i,
   input  logic [7:0]  switch_i,
   input  logic [3:0]  btn_key_row_i,
   input  logic [1:0]  btn_step_i,
   output logic [15:0] led_o,
   output logic [1:0]  led_rg0_o,
   output logic [1:0]  led_rg1_o,
   output logic [31:0] num_o,
   output logic        open_trace_o,
   output logic        num_monitor_o,
   output logic        uart_valid_o,
   output logic [7:0]  uart_data_o
);

   localparam logic [31:0] SIMU_WORD = (SIMULATION != 0) ? 32'hFFFF_FFFF : 32'h0;

   wr_state_e   wr_state_q, wr_state_d;
   rd_state_e   rd_state_q, rd_state_d;
   logic        aw_held_q, aw_held_d;
   logic        w_held_q, w_held_d;
   logic [15:0] awaddr_q, awaddr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  wstrb_q, wstrb_d;
   logic [31:0] rdata_q, rdata_d;

   logic [31:0] cr_q [8];
   logic [31:0] timer_q;
   logic [15:0] led_q;
   logic [1:0]  led_rg0_q, led_rg1_q;
   logic [31:0] num_q;
   logic        open_trace_q, num_monitor_q;
   logic        uart_valid_q;
   logic [7:0]  uart_data_q;

   logic        wr_en, ar_hs;
   logic [15:0] wr_addr, wr_word, rd_word_addr;
   logic [31:0] wr_data, wr_old, wr_merged, rd_word;
   logic [3:0]  wr_strb;
   logic        unused_addr_bits;

   // A beat accepted this cycle is usable immediately, so AW+W together commit at once
   assign wr_addr      = aw_held_q ? awaddr_q : s_awaddr_i;
   assign wr_data      = w_held_q  ? wdata_q  : s_wdata_i;
   assign wr_strb      = w_held_q  ? wstrb_q  : s_wstrb_i;
   assign wr_word      = {wr_addr[15:2], 2'b00};
   assign rd_word_addr = {s_araddr_i[15:2], 2'b00};
   assign unused_addr_bits = ^{wr_addr[1:0], s_araddr_i[1:0]};

   always_comb begin
      wr_state_d  = wr_state_q;
      aw_held_d   = aw_held_q;
      w_held_d    = w_held_q;
      awaddr_d    = awaddr_q;
      wdata_d     = wdata_q;
      wstrb_d     = wstrb_q;
      s_awready_o = 1'b0;
      s_wready_o  = 1'b0;
      s_bvalid_o  = 1'b0;
      wr_en       = 1'b0;
      case (wr_state_q)
         WR_IDLE: begin
            s_awready_o = ~aw_held_q;
            s_wready_o  = ~w_held_q;
            if ((aw_held_q || s_awvalid_i) && (w_held_q || s_wvalid_i)) begin
               wr_en      = 1'b1;
               aw_held_d  = 1'b0;
               w_held_d   = 1'b0;
               wr_state_d = WR_RESP;
            end else begin
               if (!aw_held_q && s_awvalid_i) begin
                  aw_held_d = 1'b1;
                  awaddr_d  = s_awaddr_i;
               end
               if (!w_held_q && s_wvalid_i) begin
                  w_held_d = 1'b1;
                  wdata_d  = s_wdata_i;
                  wstrb_d  = s_wstrb_i;
               end
            end
         end
         default: begin
            s_bvalid_o = 1'b1;
            if (s_bready_i) wr_state_d = WR_IDLE;
         end
      endcase
   end

   always_comb begin
      rd_state_d  = rd_state_q;
      s_arready_o = 1'b0;
      s_rvalid_o  = 1'b0;
      ar_hs       = 1'b0;
      case (rd_state_q)
         RD_IDLE: begin
            s_arready_o = 1'b1;
            if (s_arvalid_i) begin
               ar_hs      = 1'b1;
               rd_state_d = RD_DATA;
            end
         end
         default: begin
            s_rvalid_o = 1'b1;
            if (s_rready_i) rd_state_d = RD_IDLE;
         end
      endcase
   end

   always_comb begin
      rd_word = '0;
      case (rd_word_addr)
         ADDR_TIMER:       rd_word = timer_q;
         ADDR_LED:         rd_word = {16'h0, led_q};
         ADDR_LED_RG0:     rd_word = {30'h0, led_rg0_q};
         ADDR_LED_RG1:     rd_word = {30'h0, led_rg1_q};
         ADDR_NUM:         rd_word = num_q;
         ADDR_SWITCH:      rd_word = {24'h0, switch_i};
         ADDR_BTN_KEY:     rd_word = {28'h0, btn_key_row_i};
         ADDR_BTN_STEP:    rd_word = {30'h0, btn_step_i};
         ADDR_SIMU_FLAG:   rd_word = SIMU_WORD;
         ADDR_OPEN_TRACE:  rd_word = {31'h0, open_trace_q};
         ADDR_NUM_MONITOR: rd_word = {31'h0, num_monitor_q};
         default: begin
            if (s_araddr_i[15:5] == ADDR_CR0[15:5]) rd_word = cr_q[s_araddr_i[4:2]];
         end
      endcase
      rdata_d = ar_hs ? rd_word : rdata_q;
   end

   // Current contents of the targeted RW register, merged with the enabled byte lanes
   always_comb begin
      wr_old = '0;
      case (wr_word)
         ADDR_TIMER:       wr_old = timer_q;
         ADDR_LED:         wr_old = {16'h0, led_q};
         ADDR_LED_RG0:     wr_old = {30'h0, led_rg0_q};
         ADDR_LED_RG1:     wr_old = {30'h0, led_rg1_q};
         ADDR_NUM:         wr_old = num_q;
         ADDR_OPEN_TRACE:  wr_old = {31'h0, open_trace_q};
         ADDR_NUM_MONITOR: wr_old = {31'h0, num_monitor_q};
         default: begin
            if (wr_addr[15:5] == ADDR_CR0[15:5]) wr_old = cr_q[wr_addr[4:2]];
         end
      endcase
      wr_merged = apply_wstrb(wr_old, wr_data, wr_strb);
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         wr_state_q <= WR_IDLE;
         rd_state_q <= RD_IDLE;
         aw_held_q  <= 1'b0;
         w_held_q   <= 1'b0;
         awaddr_q   <= '0;
         wdata_q    <= '0;
         wstrb_q    <= '0;
         rdata_q    <= '0;
      end else begin
         wr_state_q <= wr_state_d;
         rd_state_q <= rd_state_d;
         aw_held_q  <= aw_held_d;
         w_held_q   <= w_held_d;
         awaddr_q   <= awaddr_d;
         wdata_q    <= wdata_d;
         wstrb_q    <= wstrb_d;
         rdata_q    <= rdata_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         for (int unsigned i = 0; i < 8; i++) cr_q[i] <= '0;
         timer_q       <= '0;
         led_q         <= '0;
         led_rg0_q     <= '0;
         led_rg1_q     <= '0;
         num_q         <= '0;
         open_trace_q  <= 1'b1;
         num_monitor_q <= 1'b1;
         uart_valid_q  <= 1'b0;
         uart_data_q   <= '0;
      end else begin
         timer_q      <= timer_q + 32'd1;
         uart_valid_q <= 1'b0;
         if (wr_en) begin
            case (wr_word)
               ADDR_TIMER:       timer_q       <= wr_merged;
               ADDR_LED:         led_q         <= wr_merged[15:0];
               ADDR_LED_RG0:     led_rg0_q     <= wr_merged[1:0];
               ADDR_LED_RG1:     led_rg1_q     <= wr_merged[1:0];
               ADDR_NUM:         num_q         <= wr_merged;
               ADDR_OPEN_TRACE:  open_trace_q  <= wr_merged[0];
               ADDR_NUM_MONITOR: num_monitor_q <= wr_merged[0];
               ADDR_VUART: begin
                  uart_valid_q <= 1'b1;
                  uart_data_q  <= wr_data[7:0];
               end
               default: begin
                  if (wr_addr[15:5] == ADDR_CR0[15:5]) cr_q[wr_addr[4:2]] <= wr_merged;
               end
            endcase
         end
      end
   end

   assign s_bresp_o     = RESP_OKAY;
   assign s_rresp_o     = RESP_OKAY;
   assign s_rdata_o     = rdata_q;
   assign led_o         = led_q;
   assign led_rg0_o     = led_rg0_q;
   assign led_rg1_o     = led_rg1_q;
   assign num_o         = num_q;
   assign open_trace_o  = open_trace_q;
   assign num_monitor_o = num_monitor_q;
   assign uart_valid_o  = uart_valid_q;
   assign uart_data_o   = uart_data_q;

endmodule

// File: rtl/soc_axi_lite_sys.sv
// SoC shell: confreg behind AXI-Lite, board GPIO wiring and the
// multiplexed 8-digit seven-segment scanner.
module soc_axi_lite_sys
   import soc_cfg_pkg::*;
#(
   parameter int unsigned SIMULATION = 0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] s_awaddr,
   input  logic        s_awvalid,
   output logic        s_awready,
   input  logic [31:0] s_wdata,
   input  logic [3:0]  s_wstrb,
   input  logic        s_wvalid,
   output logic        s_wready,
   output logic [1:0]  s_bresp,
   output logic        s_bvalid,
   input  logic        s_bready,
   input  logic [15:0] s_araddr,
   input  logic        s_arvalid,
   output logic        s_arready,
   output logic [31:0] s_rdata,
   output logic [1:0]  s_rresp,
   output logic        s_rvalid,
   input  logic        s_rready,
   output logic [15:0] led,
   output logic [1:0]  led_rg0,
   output logic [1:0]  led_rg1,
   output logic [7:0]  num_csn,
   output logic [6:0]  num_a_g,
   input  logic [7:0]  switch,
   output logic [3:0]  btn_key_col,
   input  logic [3:0]  btn_key_row,
   input  logic [1:0]  btn_step,
   output logic [31:0] num_data,
   output logic        num_monitor,
   output logic        open_trace,
   output logic        uart_valid,
   output logic [7:0]  uart_data
);

   localparam int unsigned CNT_W = (SIMULATION != 0) ? 4 : 20;

   logic [15:0]      led_reg;
   logic [31:0]      num_reg;
   logic [CNT_W-1:0] scan_cnt_q;
   logic [7:0]       num_csn_q;
   logic [6:0]       num_a_g_q;
   logic [2:0]       digit;
   logic [3:0]       nibble;

   confreg #(
      .SIMULATION(SIMULATION)
   ) u_confreg (
      .clk_i         (clk),
      .reset_i       (reset),
      .s_awaddr_i    (s_awaddr),
      .s_awvalid_i   (s_awvalid),
      .s_awready_o   (s_awready),
      .s_wdata_i     (s_wdata),
      .s_wstrb_i     (s_wstrb),
      .s_wvalid_i    (s_wvalid),
      .s_wready_o    (s_wready),
      .s_bresp_o     (s_bresp),
      .s_bvalid_o    (s_bvalid),
      .s_bready_i    (s_bready),
      .s_araddr_i    (s_araddr),
      .s_arvalid_i   (s_arvalid),
      .s_arready_o   (s_arready),
      .s_rdata_o     (s_rdata),
      .s_rresp_o     (s_rresp),
      .s_rvalid_o    (s_rvalid),
      .s_rready_i    (s_rready),
      .switch_i      (switch),
      .btn_key_row_i (btn_key_row),
      .btn_step_i    (btn_step),
      .led_o         (led_reg),
      .led_rg0_o     (led_rg0),
      .led_rg1_o     (led_rg1),
      .num_o         (num_reg),
      .open_trace_o  (open_trace),
      .num_monitor_o (num_monitor),
      .uart_valid_o  (uart_valid),
      .uart_data_o   (uart_data)
   );

   assign digit  = scan_cnt_q[CNT_W-1 -: 3];
   assign nibble = num_reg[{digit, 2'b00} +: 4];

   // Digit select and segment pattern are registered together so they never skew
   always_ff @(posedge clk) begin
      if (reset) begin
         scan_cnt_q <= '0;
         num_csn_q  <= 8'hFF;
         num_a_g_q  <= '0;
      end else begin
         scan_cnt_q <= scan_cnt_q + 1'b1;
         num_csn_q  <= ~(8'b0000_0001 << digit);
         num_a_g_q  <= hex2seg(nibble);
      end
   end

   assign led         = ~led_reg;
   assign num_data    = num_reg;
   assign num_csn     = num_csn_q;
   assign num_a_g     = num_a_g_q;
   assign btn_key_col = '0;

endmodule

// File: tb/tb_soc_axi_lite_sys.sv
// Directed self-checking bench for soc_axi_lite_sys with SIMULATION=1.
module tb_soc_axi_lite_sys;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] s_awaddr;
   logic        s_awvalid, s_awready;
   logic [31:0] s_wdata;
   logic [3:0]  s_wstrb;
   logic        s_wvalid, s_wready;
   logic [1:0]  s_bresp;
   logic        s_bvalid, s_bready;
   logic [15:0] s_araddr;
   logic        s_arvalid, s_arready;
   logic [31:0] s_rdata;
   logic [1:0]  s_rresp;
   logic        s_rvalid, s_rready;
   logic [15:0] led;
   logic [1:0]  led_rg0, led_rg1;
   logic [7:0]  num_csn;
   logic [6:0]  num_a_g;
   logic [7:0]  switch;
   logic [3:0]  btn_key_col, btn_key_row;
   logic [1:0]  btn_step;
   logic [31:0] num_data;
   logic        num_monitor, open_trace, uart_valid;
   logic [7:0]  uart_data;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;
   int unsigned uart_cnt = 0;
   logic [7:0]  uart_log [$];

   always #5 clk = ~clk;

   soc_axi_lite_sys #(
      .SIMULATION(1)
   ) dut (
      .clk(clk), .reset(reset),
      .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
      .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
      .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
      .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
      .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
      .led(led), .led_rg0(led_rg0), .led_rg1(led_rg1),
      .num_csn(num_csn), .num_a_g(num_a_g), .switch(switch),
      .btn_key_col(btn_key_col), .btn_key_row(btn_key_row), .btn_step(btn_step),
      .num_data(num_data), .num_monitor(num_monitor), .open_trace(open_trace),
      .uart_valid(uart_valid), .uart_data(uart_data)
   );

   always @(negedge clk) begin
      if (!reset && uart_valid) begin
         uart_cnt++;
         uart_log.push_back(uart_data);
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic axi_write(input logic [15:0] a, input logic [31:0] d,
                            input logic [3:0] s, input int unsigned bhold);
      bit done = 1'b0;
      @(posedge clk); #1;
      s_awaddr = a; s_awvalid = 1'b1;
      s_wdata = d; s_wstrb = s; s_wvalid = 1'b1; s_bready = 1'b0;
      for (int n = 0; n < 20 && !done; n++) begin
         @(negedge clk);
         if (s_awready && s_wready) done = 1'b1;
      end
      check("wr_handshake", {31'h0, done}, 32'h1);
      @(posedge clk); #1;
      s_awvalid = 1'b0; s_wvalid = 1'b0;
      @(negedge clk);
      check("bvalid_next", {31'h0, s_bvalid}, 32'h1);
      check("bresp", {30'h0, s_bresp}, 32'h0);
      for (int k = 0; k < int'(bhold); k++) begin
         if (k > 0) @(negedge clk);
         check("bvalid_hold", {31'h0, s_bvalid}, 32'h1);
         check("awready_blocked", {31'h0, s_awready}, 32'h0);
         check("wready_blocked", {31'h0, s_wready}, 32'h0);
      end
      @(posedge clk); #1 s_bready = 1'b1;
      @(posedge clk); #1 s_bready = 1'b0;
      @(negedge clk);
      check("bvalid_clear", {31'h0, s_bvalid}, 32'h0);
   endtask

   task automatic axi_read(input logic [15:0] a, output logic [31:0] d, output logic [1:0] r);
      bit done = 1'b0;
      @(posedge clk); #1;
      s_araddr = a; s_arvalid = 1'b1; s_rready = 1'b0;
      for (int n = 0; n < 20 && !done; n++) begin
         @(negedge clk);
         if (s_arready) done = 1'b1;
      end
      check("rd_handshake", {31'h0, done}, 32'h1);
      @(posedge clk); #1 s_arvalid = 1'b0;
      @(negedge clk);
      check("rvalid_next", {31'h0, s_rvalid}, 32'h1);
      d = s_rdata;
      r = s_rresp;
      @(negedge clk);
      check("rdata_stable", s_rdata, d);
      @(posedge clk); #1 s_rready = 1'b1;
      @(posedge clk); #1 s_rready = 1'b0;
   endtask

   task automatic read_expect(input string tag, input logic [15:0] a, input logic [31:0] exp);
      logic [31:0] d;
      logic [1:0]  r;
      axi_read(a, d, r);
      check(tag, d, exp);
      check("rresp", {30'h0, r}, 32'h0);
   endtask

   task automatic wait_digit(input logic [7:0] csn, input logic [6:0] seg, input string tag);
      bit found = 1'b0;
      for (int n = 0; n < 64 && !found; n++) begin
         @(negedge clk);
         if (num_csn == csn) found = 1'b1;
      end
      check({tag, "_found"}, {31'h0, found}, 32'h1);
      check(tag, {25'h0, num_a_g}, {25'h0, seg});
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      reset = 1'b1;
      s_awaddr = '0; s_awvalid = 1'b0; s_wdata = '0; s_wstrb = '0; s_wvalid = 1'b0;
      s_bready = 1'b0; s_araddr = '0; s_arvalid = 1'b0; s_rready = 1'b0;
      switch = 8'hF8; btn_key_row = 4'h5; btn_step = 2'h2;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_num_csn", {24'h0, num_csn}, 32'h0000_00FF);
      @(posedge clk); #1 reset = 1'b0;
      @(negedge clk);
      check("rst_led", {16'h0, led}, 32'h0000_FFFF);
      check("rst_num_data", num_data, 32'h0);
      check("rst_num_monitor", {31'h0, num_monitor}, 32'h1);
      check("rst_open_trace", {31'h0, open_trace}, 32'h1);
      check("rst_bvalid", {31'h0, s_bvalid}, 32'h0);
      check("rst_rvalid", {31'h0, s_rvalid}, 32'h0);
      check("rst_uart_valid", {31'h0, uart_valid}, 32'h0);
      check("btn_key_col", {28'h0, btn_key_col}, 32'h0);

      axi_write(16'hF010, 32'h0100_0001, 4'hF, 0);
      check("num_data", num_data, 32'h0100_0001);
      read_expect("rd_num", 16'hF010, 32'h0100_0001);

      axi_write(16'hF000, 32'h0000_000F, 4'hF, 0);
      check("led_full", {16'h0, led}, 32'h0000_FFF0);
      axi_write(16'hF000, 32'h0000_AB00, 4'h2, 0);
      check("led_strb", {16'h0, led}, 32'h0000_54F0);
      read_expect("rd_led", 16'hF000, 32'h0000_AB0F);

      axi_write(16'hF004, 32'hFFFF_FFFE, 4'hF, 0);
      check("led_rg0", {30'h0, led_rg0}, 32'h2);
      read_expect("rd_led_rg1", 16'hF008, 32'h0);

      axi_write(16'hFFF0, 32'h0000_0041, 4'hF, 0);
      axi_write(16'hFFF0, 32'h0000_00FF, 4'hF, 0);
      check("uart_pulses", uart_cnt, 32'd2);
      check("uart_byte0", {24'h0, (uart_log.size() > 0) ? uart_log[0] : 8'h00}, 32'h41);
      check("uart_byte1", {24'h0, (uart_log.size() > 1) ? uart_log[1] : 8'h00}, 32'hFF);
      read_expect("rd_vuart_wo", 16'hFFF0, 32'h0);

      read_expect("rd_switch", 16'hF020, 32'h0000_00F8);
      read_expect("rd_btn_key", 16'hF024, 32'h0000_0005);
      read_expect("rd_btn_step", 16'hF028, 32'h0000_0002);
      read_expect("rd_simu_flag", 16'hFFF4, 32'hFFFF_FFFF);
      read_expect("rd_unmapped", 16'h1234, 32'h0);

      axi_write(16'hF020, 32'h0000_0000, 4'hF, 0);
      read_expect("rd_switch_ro", 16'hF020, 32'h0000_00F8);
      axi_write(16'h1234, 32'hDEAD_BEEF, 4'hF, 0);
      read_expect("rd_unmapped_wr", 16'h1234, 32'h0);

      axi_write(16'h8004, 32'h1234_5678, 4'h5, 0);
      read_expect("rd_cr1", 16'h8004, 32'h0034_0078);
      read_expect("rd_cr0", 16'h8000, 32'h0);
      axi_write(16'h801C, 32'hCAFE_F00D, 4'hF, 0);
      read_expect("rd_cr7", 16'h801F, 32'hCAFE_F00D);

      // Commit at edge H; the read samples the timer in the cycle before H+4
      axi_write(16'hE000, 32'h0000_0100, 4'hF, 0);
      read_expect("rd_timer", 16'hE000, 32'h0000_0103);

      axi_write(16'hFFFC, 32'h0000_0000, 4'hF, 5);
      check("num_monitor_off", {31'h0, num_monitor}, 32'h0);
      check("open_trace_kept", {31'h0, open_trace}, 32'h1);
      read_expect("rd_num_monitor", 16'hFFFC, 32'h0);

      wait_digit(8'hFE, 7'b0110000, "seg_digit0");
      wait_digit(8'hFD, 7'b1111110, "seg_digit1");
      wait_digit(8'hBF, 7'b0110000, "seg_digit6");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
